// File: rtl/array_memory_pkg.sv
// array_memory_pkg: shared FSM encoding and default geometry for the arbitrated memory and its benches
package array_memory_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_ADDR_BITS = 3;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port combinational arbiter; last = 1 means port 1 was granted last.
// ARB_FIXED_PRIORITY_EN makes port 0 win every tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
    grant = req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00;
`else
    grant = (&req) ? (last ? 2'b01 : 2'b10) : req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00;
`endif
  end
endmodule

// File: rtl/array_memory_arbiter.sv
// array_memory_arbiter: shares one single-port memory between two requesters, one transaction per
// three cycles (IDLE -> ACCESS -> RESP). Tie policy set by ARB_FIXED_PRIORITY_EN in rr_arbiter2.
module array_memory_arbiter
  import array_memory_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 rw0,
  input  logic                 rw1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic [WIDTH-1:0]     wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [WIDTH-1:0]     rdata0,
  output logic [WIDTH-1:0]     rdata1,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [WIDTH-1:0]     mem_data_in,
  output logic                 mem_rw,
  output logic                 mem_ensure,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 busy
);
  state_t state, next;
  logic [1:0] grant;
  logic last, rw_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  rr_arbiter2 u_arb (.req({req1, req0}), .last(last), .grant(grant));
  // last doubles as the current winner once a transaction has been captured
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last <= 1'b1;
      rw_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= next;
      if (state == IDLE && (req0 || req1)) begin
        last <= grant[1];
        rw_q <= grant[1] ? rw1 : rw0;
        addr_q <= grant[1] ? addr1 : addr0;
        wdata_q <= grant[1] ? wdata1 : wdata0;
      end
      if (state == ACCESS && rw_q && last) rdata1 <= mem_rdata;
      if (state == ACCESS && rw_q && !last) rdata0 <= mem_rdata;
    end
  end
  always_comb begin
    next = state == IDLE ? ((req0 || req1) ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    mem_ensure = state == ACCESS;
    mem_rw = state == ACCESS ? rw_q : 1'b1;
    ack0 = state == RESP && !last;
    ack1 = state == RESP && last;
    busy = state != IDLE;
  end
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
endmodule

// File: tb/tb_array_memory_arbiter.sv
// tb_array_memory_arbiter: directed checks of latency, round-robin, reset abort and data path
module tb_array_memory_arbiter;
  logic clock, reset_n, req0, req1, rw0, rw1, ack0, ack1, mem_rw, mem_ensure, busy, mem_clr;
  logic [2:0] addr0, addr1, mem_address;
  logic [3:0] wdata0, wdata1, rdata0, rdata1, mem_data_in, mem_rdata;
  logic [3:0] mem [8];
  int total = 0, bad = 0;

  array_memory_arbiter #(.WIDTH(4), .ADDR_BITS(3)) dut (
    .clock(clock), .reset_n(reset_n), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_rw(mem_rw), .mem_ensure(mem_ensure), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_clr) for (int i = 0; i < 8; i++) mem[i] <= 4'd0;
    else if (mem_ensure && !mem_rw) mem[mem_address] <= mem_data_in;
  end
  assign mem_rdata = mem[mem_address];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_txn(input logic p, input logic rw, input logic [2:0] a, input logic [3:0] d,
                         output int lat, output logic [3:0] r);
    if (p) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
    lat = -1;
    r = 4'hx;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      tick();
      if (p ? ack1 : ack0) begin lat = i; r = p ? rdata1 : rdata0; end
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_reset;
    mem_clr = 1'b1;
    reset_n = 1'b0;
    {req0, req1, rw0, rw1} = 4'b0011;
    {addr0, addr1, wdata0, wdata1} = '0;
    tick();
    tick();
    mem_clr = 1'b0;
    total++; if ({ack1, ack0} !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b want=00", {ack1, ack0}); end
    total++; if ({rdata1, rdata0} !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", {rdata1, rdata0}); end
    total++; if (mem_ensure !== 1'b0) begin bad++; $display("FAIL rst_ensure got=%b want=0", mem_ensure); end
    total++; if (mem_rw !== 1'b1) begin bad++; $display("FAIL rst_rw got=%b want=1", mem_rw); end
    total++; if ({mem_address, mem_data_in} !== 7'h00) begin bad++; $display("FAIL rst_bus got=%h want=00", {mem_address, mem_data_in}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 3'd1; wdata0 = 4'd4;
    tick();
    total++; if (mem_ensure !== 1'b1) begin bad++; $display("FAIL wr_ensure got=%b want=1", mem_ensure); end
    total++; if ({mem_address, mem_rw, mem_data_in} !== {3'd1, 1'b0, 4'd4}) begin bad++; $display("FAIL wr_bus got=%h want=%h", {mem_address, mem_rw, mem_data_in}, {3'd1, 1'b0, 4'd4}); end
    total++; if ({busy, ack1, ack0} !== 3'b100) begin bad++; $display("FAIL wr_access got=%b want=100", {busy, ack1, ack0}); end
    tick();
    total++; if ({ack1, ack0} !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b want=01", {ack1, ack0}); end
    total++; if ({mem_ensure, mem_rw, mem_address} !== {1'b0, 1'b1, 3'd1}) begin bad++; $display("FAIL wr_resp_bus got=%h want=%h", {mem_ensure, mem_rw, mem_address}, {1'b0, 1'b1, 3'd1}); end
    req0 = 1'b0;
    tick();
    total++; if ({busy, ack0} !== 2'b00) begin bad++; $display("FAIL wr_idle got=%b want=00", {busy, ack0}); end
    total++; if (mem[1] !== 4'd4) begin bad++; $display("FAIL wr_mem got=%h want=4", mem[1]); end
  endtask

  task automatic test_read;
    int lat;
    logic [3:0] r;
    run_txn(1'b1, 1'b1, 3'd1, 4'd0, lat, r);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_lat got=%0d want=2", lat); end
    total++; if (r !== 4'd4) begin bad++; $display("FAIL rd_rdata1 got=%h want=4", r); end
    total++; if (rdata0 !== 4'd0) begin bad++; $display("FAIL rd_rdata0 got=%h want=0", rdata0); end
    tick();
  endtask

  task automatic test_tie;
    apply_reset();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 3'd0;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 3'd1;
    tick();
    total++; if (mem_address !== 3'd0) begin bad++; $display("FAIL tie_first_addr got=%h want=0", mem_address); end
    tick();
    total++; if ({ack1, ack0} !== 2'b01) begin bad++; $display("FAIL tie_first_ack got=%b want=01", {ack1, ack0}); end
    req0 = 1'b0;
    tick();
    total++; if ({busy, ack1} !== 2'b00) begin bad++; $display("FAIL tie_gap got=%b want=00", {busy, ack1}); end
    tick();
    total++; if ({mem_ensure, mem_address} !== {1'b1, 3'd1}) begin bad++; $display("FAIL tie_second_access got=%h want=%h", {mem_ensure, mem_address}, {1'b1, 3'd1}); end
    tick();
    total++; if ({ack1, ack0, rdata1} !== {2'b10, 4'd4}) begin bad++; $display("FAIL tie_second_ack got=%h want=%h", {ack1, ack0, rdata1}, {2'b10, 4'd4}); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_alternate;
    logic [1:0] exp;
    apply_reset();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 3'd1;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 3'd1;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef ARB_FIXED_PRIORITY_EN
      exp = (k % 3 == 2) ? 2'b01 : 2'b00;
`else
      exp = (k % 3 != 2) ? 2'b00 : (((k - 2) / 3) % 2 == 1) ? 2'b10 : 2'b01;
`endif
      total++; if ({ack1, ack0} !== exp) begin bad++; $display("FAIL alt_ack cycle=%0d got=%b want=%b", k, {ack1, ack0}, exp); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 3'd5; wdata0 = 4'd9;
    tick();
    total++; if (mem_ensure !== 1'b1) begin bad++; $display("FAIL rm_access got=%b want=1", mem_ensure); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({mem_ensure, mem_rw, busy, ack1, ack0} !== 5'b01000) begin bad++; $display("FAIL rm_ctrl got=%b want=01000", {mem_ensure, mem_rw, busy, ack1, ack0}); end
    total++; if ({mem_address, mem_data_in, rdata1, rdata0} !== 15'h0) begin bad++; $display("FAIL rm_data got=%h want=0", {mem_address, mem_data_in, rdata1, rdata0}); end
    req0 = 1'b0;
    tick();
    total++; if ({mem_ensure, ack1, ack0} !== 3'b000) begin bad++; $display("FAIL rm_hold got=%b want=000", {mem_ensure, ack1, ack0}); end
    reset_n = 1'b1;
    tick();
    total++; if ({mem_ensure, ack0, busy} !== 3'b000) begin bad++; $display("FAIL rm_after got=%b want=000", {mem_ensure, ack0, busy}); end
    total++; if (mem[5] !== 4'd0) begin bad++; $display("FAIL rm_mem got=%h want=0", mem[5]); end
  endtask

  task automatic test_wrap;
    int lat;
    logic [3:0] r;
    run_txn(1'b1, 1'b0, 3'd7, 4'd7, lat, r);
    total++; if (lat !== 2) begin bad++; $display("FAIL wrap_wr_lat got=%0d want=2", lat); end
    tick();
    total++; if (mem[7] !== 4'd7) begin bad++; $display("FAIL wrap_mem got=%h want=7", mem[7]); end
    run_txn(1'b0, 1'b1, 3'd7, 4'd0, lat, r);
    total++; if (lat !== 2) begin bad++; $display("FAIL wrap_rd_lat got=%0d want=2", lat); end
    total++; if (r !== 4'd7) begin bad++; $display("FAIL wrap_rdata0 got=%h want=7", r); end
    total++; if (rdata1 !== 4'd0) begin bad++; $display("FAIL wrap_rdata1 got=%h want=0", rdata1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_alternate();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule
